matrix_operand_loader: RTL and testbench
========================================

// Module: matrix_operand_loader
// PURPOSE
//   Upstream feeder for the large matrix multiplier. Fetches MATRIX_WIDTH x MATRIX_WIDTH operand
//   matrices A and B (column-major, WIDTH-bit elements) from a single-word memory port. Packs them
//   into NUM_ELEMENTS-wide beats and drives the multiplier's rdata/read_en load interface.
//   One outstanding memory request at a time; start/busy/done control from the system sequencer.
// PARAMETERS
//   WIDTH         8    bits per matrix element
//   NUM_ELEMENTS  4    elements per output beat (fixed: 2 of A, 2 of B)
//   MATRIX_WIDTH  4    matrix dimension; even, >= 2
//   ADDR_WIDTH    16   memory address width
//   A_BASE        0    word address of A[0][0]
//   B_BASE        16   word address of B[0][0]
// PORTS
//   clk        in   1                   single clock, all logic on posedge
//   reset      in   1                   synchronous, active-high
//   start      in   1                   begin load; sampled only in IDLE
//   busy       out  1                   high in any state other than IDLE
//   done       out  1                   one-cycle pulse after last beat issued
//   mem_rd_en  out  1                   one-cycle read request
//   mem_addr   out  ADDR_WIDTH          request address, valid with mem_rd_en
//   mem_rvalid in   1                   read data valid (latency >= 1 cycle after request)
//   mem_rdata  in   WIDTH               read data
//   read_en    out  1                   one-cycle beat strobe to multiplier
//   rdata      out  NUM_ELEMENTS*WIDTH  beat data, valid with read_en
// BEHAVIOUR
//   - Reset: state IDLE; busy, done, mem_rd_en, read_en = 0; mem_addr, rdata = 0; counters = 0.
//   - Element address: X[r][c] at X_BASE + c*MATRIX_WIDTH + r, modulo 2^ADDR_WIDTH.
//   - Beats: b = 0 .. MATRIX_WIDTH*MATRIX_WIDTH/2-1; r = 2*(b mod (MATRIX_WIDTH/2)),
//     c = b / (MATRIX_WIDTH/2). Row advances by 2 and wraps to 0 when c increments.
//   - Beat packing (MSB first): rdata = {A[r][c], A[r+1][c], B[r][c], B[r+1][c]}.
//   - FSM: IDLE -start-> REQ -> WAIT -(mem_rvalid)-> REQ (next slot) | ISSUE (after slot 3).
//     ISSUE -> REQ (next beat) | DONE (last beat). DONE -> IDLE.
//   - REQ: mem_rd_en=1 for exactly one cycle; mem_addr holds the slot address.
//   - WAIT: capture mem_rdata into slot register on mem_rvalid.
//   - ISSUE: read_en=1 for exactly one cycle; rdata updated the same cycle and held until next ISSUE.
//   - DONE: done=1 for one cycle; busy stays 1 in DONE.
//   - Latency, memory latency L=1: first read_en 9 cycles after start sampled; beats 9 cycles apart;
//     4x4 load issues 8 beats; done 1 cycle after last read_en.
//   - start while busy: ignored. mem_rvalid outside WAIT: ignored, data discarded.
//   - Reset mid-load: immediate return to IDLE, no further beats. A response outstanding at reset
//     is dropped.
//   - No backpressure on read_en; the multiplier must accept every beat.
// CONFIGURATION
//   LOADER_CHKSUM_EN defined: adds output port chksum [15:0].
//     - Cleared on reset and on accepted start.
//     - Adds each captured element (zero-extended) mod 2^16.
//     - Stable from done until next start.
//   LOADER_CHKSUM_EN undefined: no chksum port and no accumulator logic; all other behaviour identical.
// TESTING
//   1. Reset -> busy=done=read_en=mem_rd_en=0, rdata=0; all hold with start=0 for 20 cycles.
//   2. Memory mem[a]=a[7:0], L=1, pulse start -> 8 beats 9 cycles apart:
//      beat0 rdata=0x00011011, beat1 0x02031213, beat7 0x0E0F1E1F; done pulse 1 cycle after beat7.
//   3. Random L in 1..5 per request -> same 8 rdata values; one request outstanding at a time.
//   4. start held high throughout load -> exactly one load of 8 beats.
//      Next load begins 1 cycle after returning to IDLE.
//   5. reset asserted after beat 3 with a request outstanding -> IDLE next cycle, late mem_rvalid
//      ignored; new start gives beat0=0x00011011.
//   6. LOADER_CHKSUM_EN defined, stimulus of test 2 -> chksum=0x01F0 at done.

Source files
------------

// File: rtl/matrix_operand_loader.sv
// Purpose : Fetches column-major MATRIX_WIDTH x MATRIX_WIDTH operands A and B from a
//           single-word memory port, one outstanding request at a time, and packs them
//           into beats {A[r][c], A[r+1][c], B[r][c], B[r+1][c]} for the matrix multiplier.
// Ports   : clk/reset (sync, active-high); start/busy/done sequencer handshake;
//           mem_rd_en/mem_addr request, mem_rvalid/mem_rdata response;
//           read_en/rdata beat strobe and data (no backpressure).
// Config  : define LOADER_CHKSUM_EN to add a 16-bit running sum of captured elements (chksum).
module matrix_operand_loader #(
  parameter int WIDTH        = 8,
  parameter int NUM_ELEMENTS = 4,
  parameter int MATRIX_WIDTH = 4,
  parameter int ADDR_WIDTH   = 16,
  parameter int A_BASE       = 0,
  parameter int B_BASE       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_rd_en,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic                          mem_rvalid,
  input  logic [WIDTH-1:0]              mem_rdata,
  output logic                          read_en,
  output logic [NUM_ELEMENTS*WIDTH-1:0] rdata
`ifdef LOADER_CHKSUM_EN
  ,
  output logic [15:0]                   chksum
`endif
);

  localparam int CW = $clog2(MATRIX_WIDTH);
  localparam logic [CW-1:0] ROW_LAST = CW'(MATRIX_WIDTH - 2);
  localparam logic [CW-1:0] COL_LAST = CW'(MATRIX_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] A_BASE_W = ADDR_WIDTH'(A_BASE);
  localparam logic [ADDR_WIDTH-1:0] B_BASE_W = ADDR_WIDTH'(B_BASE);
  localparam logic [ADDR_WIDTH-1:0] MW_W     = ADDR_WIDTH'(MATRIX_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // row/col locate the current beat; slot selects which of its four elements is fetched:
  // slot[1] picks the matrix (0=A, 1=B), slot[0] picks row r or r+1.
  logic [CW-1:0]                   row, col;
  logic [1:0]                      slot;
  logic [WIDTH-1:0]                slot0, slot1, slot2;
  logic [NUM_ELEMENTS*WIDTH-1:0]   rdata_q;
  logic [ADDR_WIDTH-1:0]           slot_addr;
  logic                            last_beat;
`ifdef LOADER_CHKSUM_EN
  logic [15:0]                     chksum_q;
`endif

  always_comb begin
    slot_addr = (slot[1] ? B_BASE_W : A_BASE_W)
              + ADDR_WIDTH'(col) * MW_W
              + ADDR_WIDTH'(row)
              + ADDR_WIDTH'(slot[0]);
  end

  assign last_beat = (row == ROW_LAST) && (col == COL_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_REQ;
      S_REQ:   state_nxt = S_WAIT;
      S_WAIT:  if (mem_rvalid) state_nxt = (slot == 2'd3) ? S_ISSUE : S_REQ;
      S_ISSUE: state_nxt = last_beat ? S_DONE : S_REQ;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs: every strobe lasts exactly the one cycle spent in its state.
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign mem_rd_en = (state == S_REQ);
  assign read_en   = (state == S_ISSUE);
  assign mem_addr  = (state == S_REQ) ? slot_addr : '0;
  assign rdata     = rdata_q;
`ifdef LOADER_CHKSUM_EN
  assign chksum    = chksum_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      row     <= '0;
      col     <= '0;
      slot    <= '0;
      slot0   <= '0;
      slot1   <= '0;
      slot2   <= '0;
      rdata_q <= '0;
`ifdef LOADER_CHKSUM_EN
      chksum_q <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            row  <= '0;
            col  <= '0;
            slot <= '0;
`ifdef LOADER_CHKSUM_EN
            chksum_q <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            slot <= slot + 2'd1;
            // The fourth element goes straight into the beat register, so rdata is
            // already valid in the ISSUE cycle and holds until the next beat.
            case (slot)
              2'd0:    slot0   <= mem_rdata;
              2'd1:    slot1   <= mem_rdata;
              2'd2:    slot2   <= mem_rdata;
              default: rdata_q <= {slot0, slot1, slot2, mem_rdata};
            endcase
`ifdef LOADER_CHKSUM_EN
            chksum_q <= chksum_q + 16'(mem_rdata);
`endif
          end
        end
        S_ISSUE: begin
          if (row == ROW_LAST) begin
            row <= '0;
            col <= col + CW'(1);
          end else begin
            row <= row + CW'(2);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Bench for matrix_operand_loader: table-driven beat checks plus randomized memory
// latency/contents compared against a matrix-index reference model.
module tb_matrix_operand_loader;

  localparam int WIDTH = 8;
  localparam int NE    = 4;
  localparam int MW    = 4;
  localparam int AW    = 16;
  localparam int A_B   = 0;
  localparam int B_B   = 16;
  localparam int NBEAT = MW * MW / 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, mem_rd_en, read_en;
  logic [AW-1:0] mem_addr;
  logic          mem_rvalid = 1'b0;
  logic [7:0]    mem_rdata = 8'h00;
  logic [31:0]   rdata;
`ifdef LOADER_CHKSUM_EN
  logic [15:0]   chksum;
`endif

  matrix_operand_loader #(
    .WIDTH(WIDTH), .NUM_ELEMENTS(NE), .MATRIX_WIDTH(MW), .ADDR_WIDTH(AW),
    .A_BASE(A_B), .B_BASE(B_B)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .read_en(read_en), .rdata(rdata)
`ifdef LOADER_CHKSUM_EN
    ,
    .chksum(chksum)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem_arr [256];
  int  lat_cfg = 1;       // 0 = random latency 1..5 per request
  bit  stray_en = 1'b0;   // inject rvalid pulses when the DUT is not waiting
  int  pend_cnt = 0;
  logic [AW-1:0] pend_addr = '0;
  int  overlap_err = 0;

  // Memory model: responds L cycles after the request cycle; responses are not
  // cancelled by DUT reset so a late response can reach an idle loader.
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    mem_rdata  = 8'($urandom);
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_arr[pend_addr[7:0]];
      end
    end
    if (mem_rd_en) begin
      if (pend_cnt > 0) overlap_err++;
      pend_addr = mem_addr;
      pend_cnt  = (lat_cfg == 0) ? int'($urandom_range(1, 5)) : lat_cfg;
      if (stray_en && !mem_rvalid && $urandom_range(0, 1) == 1) mem_rvalid = 1'b1;
    end else if (stray_en && !busy && !mem_rvalid && $urandom_range(0, 3) == 0) begin
      mem_rvalid = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: beat b straight from the matrix index rules.
  function automatic logic [31:0] model_beat(input int b);
    int r, c, a, bb;
    r  = 2 * (b % (MW / 2));
    c  = b / (MW / 2);
    a  = (A_B + c * MW + r) % 256;
    bb = (B_B + c * MW + r) % 256;
    return {mem_arr[a], mem_arr[(a + 1) % 256], mem_arr[bb], mem_arr[(bb + 1) % 256]};
  endfunction

  function automatic logic [15:0] model_sum();
    logic [15:0] s = 16'h0;
    for (int i = 0; i < MW * MW; i++) begin
      s = s + 16'(mem_arr[(A_B + i) % 256]) + 16'(mem_arr[(B_B + i) % 256]);
    end
    return s;
  endfunction

  logic [31:0] beat_dat [32];
  int          beat_cyc [32];

  task automatic start_load(input bit hold, output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // Record beats until done, bounded.
  task automatic collect(output int n, output int d, output bit dbusy);
    n = 0;
    d = -1;
    dbusy = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (read_en) begin
        if (n < 32) begin
          beat_dat[n] = rdata;
          beat_cyc[n] = cyc;
        end
        n++;
      end
      if (done) begin
        d = cyc;
        dbusy = busy;
        break;
      end
    end
    if (d < 0) begin
      checks++;
      failures++;
      $display("FAIL load_timeout beats=%0d done_seen=0 required=done within 600 cycles", n);
    end
  endtask

  task automatic check_vs_model(input string tag, input int n);
    chk({tag, "_nbeats"}, 64'(n), 64'(NBEAT));
    for (int b = 0; b < NBEAT && b < n; b++)
      chk($sformatf("%s_beat%0d", tag, b), 64'(beat_dat[b]), 64'(model_beat(b)));
`ifdef LOADER_CHKSUM_EN
    chk({tag, "_chksum"}, 64'(chksum), 64'(model_sum()));
`endif
  endtask

  typedef struct {
    int          beat;
    logic [31:0] exp_rdata;
    int          exp_ofs;    // cycles from start-drive cycle to read_en
  } vec_t;

  initial begin
    vec_t tbl [NBEAT];
    int s0, nb, dcyc, bad;
    bit dbusy;

    tbl[0] = '{0, 32'h00011011,  9};
    tbl[1] = '{1, 32'h02031213, 18};
    tbl[2] = '{2, 32'h04051415, 27};
    tbl[3] = '{3, 32'h06071617, 36};
    tbl[4] = '{4, 32'h08091819, 45};
    tbl[5] = '{5, 32'h0A0B1A1B, 54};
    tbl[6] = '{6, 32'h0C0D1C1D, 63};
    tbl[7] = '{7, 32'h0E0F1E1F, 72};

    for (int i = 0; i < 256; i++) mem_arr[i] = i[7:0];

    // Reset state and idle hold
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_read_en", 64'(read_en), 64'd0);
    chk("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || done || read_en || mem_rd_en || rdata != 32'h0) bad++;
    end
    chk("idle_hold_nonzero_cycles", 64'(bad), 64'd0);

    // Fixed latency 1, identity memory: table of beat values and timing
    lat_cfg = 1;
    start_load(1'b0, s0);
    collect(nb, dcyc, dbusy);
    chk("t2_nbeats", 64'(nb), 64'(NBEAT));
    for (int i = 0; i < NBEAT; i++) begin
      chk($sformatf("t2_rdata_b%0d", tbl[i].beat), 64'(beat_dat[tbl[i].beat]),
          64'(tbl[i].exp_rdata));
      chk($sformatf("t2_cycle_b%0d", tbl[i].beat), 64'(beat_cyc[tbl[i].beat] - s0),
          64'(tbl[i].exp_ofs));
    end
    chk("t2_done_after_last", 64'(dcyc - beat_cyc[NBEAT-1]), 64'd1);
    chk("t2_busy_in_done", 64'(dbusy), 64'd1);
`ifdef LOADER_CHKSUM_EN
    chk("t6_chksum_at_done", 64'(chksum), 64'h01F0);
`endif
    @(negedge clk);
    chk("t2_idle_after_done", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    chk("t2_rdata_held", 64'(rdata), 64'h0E0F1E1F);
`ifdef LOADER_CHKSUM_EN
    chk("t6_chksum_stable", 64'(chksum), 64'h01F0);
`endif

    // Random latency, identity memory, against the table values
    lat_cfg = 0;
    start_load(1'b0, s0);
    collect(nb, dcyc, dbusy);
    chk("t3_nbeats", 64'(nb), 64'(NBEAT));
    for (int i = 0; i < NBEAT; i++)
      chk($sformatf("t3_rdata_b%0d", i), 64'(beat_dat[i]), 64'(tbl[i].exp_rdata));

    // Random contents, random latency, stray rvalid pulses, against the model
    stray_en = 1'b1;
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 256; i++) mem_arr[i] = 8'($urandom);
      repeat (3) @(negedge clk);
      start_load(1'b0, s0);
      collect(nb, dcyc, dbusy);
      check_vs_model($sformatf("rnd%0d", rep), nb);
    end
    stray_en = 1'b0;
    for (int i = 0; i < 256; i++) mem_arr[i] = i[7:0];

    // start held high through a load: exactly one load, next begins right after IDLE
    lat_cfg = 1;
    repeat (3) @(negedge clk);
    start_load(1'b1, s0);
    collect(nb, dcyc, dbusy);
    chk("t4_nbeats", 64'(nb), 64'(NBEAT));
    @(negedge clk);
    chk("t4_idle_between", 64'(busy), 64'd0);
    @(negedge clk);
    chk("t4_restart_req", 64'(mem_rd_en), 64'd1);
    chk("t4_restart_addr", 64'(mem_addr), 64'(A_B));
    start = 1'b0;
    collect(nb, dcyc, dbusy);
    check_vs_model("t4_second", nb);

    // Reset mid-load with a response outstanding
    lat_cfg = 5;
    repeat (3) @(negedge clk);
    start_load(1'b0, s0);
    nb = 0;
    for (int i = 0; i < 600 && nb < 4; i++) begin
      @(negedge clk);
      if (read_en) nb++;
    end
    chk("t5_beats_before_reset", 64'(nb), 64'd4);
    bad = 1;
    for (int i = 0; i < 100; i++) begin
      if (mem_rd_en) begin
        bad = 0;
        break;
      end
      @(negedge clk);
    end
    chk("t5_request_seen", 64'(bad), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_busy_after_reset", 64'(busy), 64'd0);
    chk("t5_read_en_after_reset", 64'(read_en), 64'd0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy || read_en || mem_rd_en || done) bad++;
    end
    chk("t5_quiet_after_reset", 64'(bad), 64'd0);
    lat_cfg = 1;
    start_load(1'b0, s0);
    collect(nb, dcyc, dbusy);
    chk("t5_new_beat0", 64'(beat_dat[0]), 64'h00011011);
    check_vs_model("t5_new", nb);

    chk("one_outstanding_violations", 64'(overlap_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
